// File: rtl/mod_pow_seq.sv
// Sequential right-to-left binary modular exponentiator, one exponent bit per clock.
// Valid/ready on both sides; a zero modulus completes with out_err set.
module mod_pow_seq #(
   parameter int WIDTH     = 8,
   parameter int EXP_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_a,
   input  logic [EXP_WIDTH-1:0] in_b,
   input  logic [WIDTH-1:0]     in_n,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_result,
   output logic                 out_err
);

   localparam int PW = 2 * WIDTH;

   typedef enum logic [1:0] {
      S_IDLE,
      S_INIT,
      S_LOOP,
      S_DONE
   } state_t;

   state_t               r_state;
   logic [WIDTH-1:0]     r_base;
   logic [WIDTH-1:0]     r_res;
   logic [EXP_WIDTH-1:0] r_exp;
   logic [WIDTH-1:0]     r_mod;
   logic [WIDTH-1:0]     r_a;
   logic [WIDTH-1:0]     r_result;
   logic                 r_err;
   logic                 r_in_ready;
   logic                 r_out_valid;

   logic [WIDTH-1:0]     w_mod_nz;
   logic [PW-1:0]        w_m2;
   logic [PW-1:0]        w_a_ext;
   logic [PW-1:0]        w_res_ext;
   logic [PW-1:0]        w_base_ext;
   logic [PW-1:0]        w_a_red;
   logic [PW-1:0]        w_rb;
   logic [PW-1:0]        w_bb;
   logic [WIDTH-1:0]     w_res_nxt;
   logic [WIDTH-1:0]     w_res_init;
   logic [EXP_WIDTH-1:0] w_exp_sh;

   // Divisor forced non-zero so the idle/err paths never divide by zero.
   assign w_mod_nz   = (r_mod == '0) ? WIDTH'(1) : r_mod;
   assign w_m2       = {{WIDTH{1'b0}}, w_mod_nz};
   assign w_a_ext    = {{WIDTH{1'b0}}, r_a};
   assign w_res_ext  = {{WIDTH{1'b0}}, r_res};
   assign w_base_ext = {{WIDTH{1'b0}}, r_base};
   assign w_a_red    = w_a_ext % w_m2;
   assign w_rb       = (w_res_ext * w_base_ext) % w_m2;
   assign w_bb       = (w_base_ext * w_base_ext) % w_m2;
   assign w_res_nxt  = r_exp[0] ? w_rb[WIDTH-1:0] : r_res;
   assign w_res_init = (r_mod == WIDTH'(1)) ? '0 : WIDTH'(1);
   assign w_exp_sh   = r_exp >> 1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_base      <= '0;
         r_res       <= '0;
         r_exp       <= '0;
         r_mod       <= '0;
         r_a         <= '0;
         r_result    <= '0;
         r_err       <= 1'b0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (in_valid && r_in_ready) begin
                  r_a        <= in_a;
                  r_exp      <= in_b;
                  r_mod      <= in_n;
                  r_in_ready <= 1'b0;
                  r_state    <= S_INIT;
               end
            end
            S_INIT: begin
               if (r_mod == '0) begin
                  r_res       <= '0;
                  r_result    <= '0;
                  r_err       <= 1'b1;
                  r_out_valid <= 1'b1;
                  r_state     <= S_DONE;
               end else begin
                  r_base <= w_a_red[WIDTH-1:0];
                  r_res  <= w_res_init;
                  r_err  <= 1'b0;
                  if (r_exp == '0) begin
                     r_result    <= w_res_init;
                     r_out_valid <= 1'b1;
                     r_state     <= S_DONE;
                  end else begin
                     r_state <= S_LOOP;
                  end
               end
            end
            S_LOOP: begin
               r_res  <= w_res_nxt;
               r_base <= w_bb[WIDTH-1:0];
               r_exp  <= w_exp_sh;
               // Early exit once no set exponent bits remain.
               if (w_exp_sh == '0) begin
                  r_result    <= w_res_nxt;
                  r_out_valid <= 1'b1;
                  r_state     <= S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
         endcase
      end
   end

   assign in_ready   = r_in_ready;
   assign out_valid  = r_out_valid;
   assign out_result = r_result;
   assign out_err    = r_err;

endmodule
